// File: rtl/rf_wb_ctl.sv
// Register-file write-back controller: merges ALU/load/mul-div results through an in-order queue.
// Optional per-register pending bitmap is built when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_ctl #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        alu_wr_i,
   input  logic [4:0]  alu_addr_i,
   input  logic [31:0] alu_data_i,
   input  logic        mem_wr_i,
   input  logic [4:0]  mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic        md_wr_i,
   input  logic [4:0]  md_addr_i,
   input  logic [31:0] md_data_i,
   output logic        wren,
   output logic [4:0]  wraddress,
   output logic [31:0] data,
   output logic        stall_o,
   output logic        ovf_o,
   output logic [31:0] pend_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NSRC  = 3;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - 3);

   logic [4:0]       q_addr [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [CNT_W-1:0] space;

   logic             req_v [NSRC];
   logic [4:0]       req_a [NSRC];
   logic [31:0]      req_d [NSRC];
   logic             push_cand [NSRC];
   logic             push_en [NSRC];
   logic [4:0]       push_a [NSRC];
   logic [31:0]      push_d [NSRC];
   logic [1:0]       n_acc;
   logic             pop;
   logic             drop;

   logic             sel_vld_p0;
   logic [4:0]       sel_addr_p0;
   logic [31:0]      sel_data_p0;

   // Index order is the retire priority; register 0 is never a real destination.
   always_comb begin
      req_v[0] = alu_wr_i & (alu_addr_i != 5'd0);
      req_a[0] = alu_addr_i;
      req_d[0] = alu_data_i;
      req_v[1] = mem_wr_i & (mem_addr_i != 5'd0);
      req_a[1] = mem_addr_i;
      req_d[1] = mem_data_i;
      req_v[2] = md_wr_i & (md_addr_i != 5'd0);
      req_a[2] = md_addr_i;
      req_d[2] = md_data_i;
   end

   // ---- stage 0: select one candidate, compact the surplus into queue slots ----
   always_comb begin
      sel_vld_p0  = 1'b0;
      sel_addr_p0 = '0;
      sel_data_p0 = '0;
      pop         = 1'b0;
      drop        = 1'b0;
      n_acc       = '0;
      for (int i = 0; i < NSRC; i++) begin
         push_cand[i] = req_v[i];
         push_en[i]   = 1'b0;
         push_a[i]    = '0;
         push_d[i]    = '0;
      end
      if (count != '0) begin
         pop         = 1'b1;
         sel_vld_p0  = 1'b1;
         sel_addr_p0 = q_addr[rd_ptr];
         sel_data_p0 = q_data[rd_ptr];
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (req_v[i] && !sel_vld_p0) begin
               sel_vld_p0   = 1'b1;
               sel_addr_p0  = req_a[i];
               sel_data_p0  = req_d[i];
               push_cand[i] = 1'b0;
            end
         end
      end
      // The pop frees its slot before any push is counted against capacity.
      space = DEPTH_C - count + CNT_W'(pop);
      for (int i = 0; i < NSRC; i++) begin
         if (push_cand[i]) begin
            if (CNT_W'(n_acc) < space) begin
               push_en[n_acc] = 1'b1;
               push_a[n_acc]  = req_a[i];
               push_d[n_acc]  = req_d[i];
               n_acc          = n_acc + 2'd1;
            end else begin
               drop = 1'b1;
            end
         end
      end
      count_next = count - CNT_W'(pop) + CNT_W'(n_acc);
   end

   always_ff @(posedge clock) begin
      for (int j = 0; j < NSRC; j++) begin
         if (push_en[j]) begin
            q_addr[wr_ptr + PTR_W'(j)] <= push_a[j];
            q_data[wr_ptr + PTR_W'(j)] <= push_d[j];
         end
      end
   end

   // ---- stage 1: queue control and register-file output register ----
   always_ff @(posedge clock) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         stall_o   <= 1'b0;
         ovf_o     <= 1'b0;
         wren      <= 1'b0;
         wraddress <= '0;
         data      <= '0;
      end else begin
         rd_ptr  <= rd_ptr + PTR_W'(pop);
         wr_ptr  <= wr_ptr + PTR_W'(n_acc);
         count   <= count_next;
         stall_o <= (count_next > STALL_TH);
         if (drop) begin
            ovf_o <= 1'b1;
         end
         wren <= sel_vld_p0;
         if (sel_vld_p0) begin
            wraddress <= sel_addr_p0;
            data      <= sel_data_p0;
         end
      end
   end

`ifdef RF_WB_SCOREBOARD_EN
   localparam int PC_W = CNT_W + 1;

   logic            byp;
   logic [1:0]      pend_inc [32];
   logic [PC_W-1:0] pend_cnt [32];

   assign byp = sel_vld_p0 & ~pop;

   // A popped entry moves from queue to output register, so only bypasses and pushes add.
   always_comb begin
      for (int n = 0; n < 32; n++) begin
         pend_inc[n] = '0;
         for (int j = 0; j < NSRC; j++) begin
            if (push_en[j] && (push_a[j] == 5'(n))) begin
               pend_inc[n] = pend_inc[n] + 2'd1;
            end
         end
         if (byp && (sel_addr_p0 == 5'(n))) begin
            pend_inc[n] = pend_inc[n] + 2'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         for (int n = 0; n < 32; n++) begin
            pend_cnt[n] <= '0;
         end
      end else begin
         for (int n = 1; n < 32; n++) begin
            pend_cnt[n] <= pend_cnt[n] + PC_W'(pend_inc[n])
                           - PC_W'(wren && (wraddress == 5'(n)));
         end
      end
   end

   always_comb begin
      pend_o = '0;
      for (int n = 1; n < 32; n++) begin
         pend_o[n] = (pend_cnt[n] != '0);
      end
   end
`else
   assign pend_o = 32'h0;
`endif

endmodule

// File: tb/tb_rf_wb_ctl.sv
// Scoreboard bench for rf_wb_ctl: a queue-based reference model predicts writes and status per cycle.
// Pending-bitmap expectations follow RF_WB_SCOREBOARD_EN.
module tb_rf_wb_ctl;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        alu_wr_i = 1'b0, mem_wr_i = 1'b0, md_wr_i = 1'b0;
   logic [4:0]  alu_addr_i = '0, mem_addr_i = '0, md_addr_i = '0;
   logic [31:0] alu_data_i = '0, mem_data_i = '0, md_data_i = '0;
   logic        wren, stall_o, ovf_o;
   logic [4:0]  wraddress;
   logic [31:0] data, pend_o;

   rf_wb_ctl #(.DEPTH(DEPTH)) dut (
      .clock(clock), .rst(rst),
      .alu_wr_i(alu_wr_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
      .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
      .md_wr_i(md_wr_i), .md_addr_i(md_addr_i), .md_data_i(md_data_i),
      .wren(wren), .wraddress(wraddress), .data(data),
      .stall_o(stall_o), .ovf_o(ovf_o), .pend_o(pend_o)
   );

   always #5 clock = ~clock;

   typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
   typedef struct { int cyc; bit wren; bit stall; bit ovf; logic [31:0] pend; } ctl_t;

   wr_t  exp_wr[$];
   ctl_t exp_ctl[$];
   wr_t  mq[$];
   bit   m_ovf = 1'b0;
   bit   m_stall = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Reference: a plain FIFO of pending writes, oldest first, then ALU, MEM, MD.
   task automatic model_step(input bit r, input wr_t req_in [3], input bit v_in [3]);
      wr_t  reqs[$];
      wr_t  out;
      bit   has_out;
      ctl_t c;
      c.cyc = cyc + 1;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_stall = 1'b0;
         c.wren = 1'b0; c.stall = 1'b0; c.ovf = 1'b0; c.pend = '0;
         exp_ctl.push_back(c);
         return;
      end
      for (int i = 0; i < 3; i++)
         if (v_in[i] && req_in[i].a != 5'd0) reqs.push_back(req_in[i]);
      has_out = 1'b0;
      if (mq.size() > 0) begin
         out = mq.pop_front();
         has_out = 1'b1;
      end else if (reqs.size() > 0) begin
         out = reqs.pop_front();
         has_out = 1'b1;
      end
      foreach (reqs[i]) begin
         if (mq.size() < DEPTH) mq.push_back(reqs[i]);
         else m_ovf = 1'b1;
      end
      if (has_out) exp_wr.push_back(out);
      m_stall = (mq.size() > DEPTH - 3);
      c.wren = has_out;
      c.stall = m_stall;
      c.ovf = m_ovf;
      c.pend = '0;
`ifdef RF_WB_SCOREBOARD_EN
      foreach (mq[i]) c.pend[mq[i].a] = 1'b1;
      if (has_out) c.pend[out.a] = 1'b1;
`endif
      exp_ctl.push_back(c);
   endtask

   task automatic step(input bit r,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit dv, input logic [4:0] da, input logic [31:0] dd);
      wr_t req [3];
      bit  v [3];
      @(posedge clock);
      #1;
      rst = r;
      alu_wr_i = av; alu_addr_i = aa; alu_data_i = ad;
      mem_wr_i = mv; mem_addr_i = ma; mem_data_i = md;
      md_wr_i = dv;  md_addr_i = da;  md_data_i = dd;
      req[0] = '{a: aa, d: ad}; v[0] = av;
      req[1] = '{a: ma, d: md}; v[1] = mv;
      req[2] = '{a: da, d: dd}; v[2] = dv;
      model_step(r, req, v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic triple(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      step(0, 1, a0, 32'hA000_0000 | 32'(a0), 1, a1, 32'hB000_0000 | 32'(a1),
           1, a2, 32'hC000_0000 | 32'(a2));
   endtask

   // Monitor: compares writes when wren is seen and status once per tagged cycle.
   always @(negedge clock) begin
      wr_t  e;
      ctl_t c;
      if (wren) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_extra: got addr=%0d data=%h, required no write", wraddress, data);
         end else begin
            e = exp_wr.pop_front();
            if (wraddress !== e.a || data !== e.d) begin
               errors++;
               $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                        wraddress, data, e.a, e.d);
            end
         end
      end
      if (exp_ctl.size() > 0 && exp_ctl[0].cyc <= cyc) begin
         c = exp_ctl.pop_front();
         checks++;
         if (c.cyc != cyc) begin
            errors++;
            $display("FAIL ctl_align: got cycle %0d, required %0d", cyc, c.cyc);
         end
         checks++;
         if (wren !== c.wren) begin
            errors++;
            $display("FAIL wren: cycle %0d got %b, required %b", cyc, wren, c.wren);
         end
         checks++;
         if (stall_o !== c.stall) begin
            errors++;
            $display("FAIL stall: cycle %0d got %b, required %b", cyc, stall_o, c.stall);
         end
         checks++;
         if (ovf_o !== c.ovf) begin
            errors++;
            $display("FAIL ovf: cycle %0d got %b, required %b", cyc, ovf_o, c.ovf);
         end
         checks++;
         if (pend_o !== c.pend) begin
            errors++;
            $display("FAIL pend: cycle %0d got %h, required %h", cyc, pend_o, c.pend);
         end
      end
   end

   initial begin
      bit r, ok, av, mv, dv;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // single ALU write with bypass
      step(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
      idle(2);
      // register 0 is filtered
      step(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
      idle(2);
      // triple collision
      triple(5'd3, 5'd4, 5'd5);
      idle(4);
      // same destination from MEM and MD
      step(0, 0, 0, 0, 1, 5'd7, 32'h0000_7777, 1, 5'd7, 32'h7777_0000);
      idle(4);
      // reset while draining
      triple(5'd10, 5'd11, 5'd12);
      triple(5'd13, 5'd14, 5'd15);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(6);
      // overflow, stall ignored
      triple(5'd1, 5'd2, 5'd3);
      triple(5'd4, 5'd5, 5'd6);
      triple(5'd7, 5'd8, 5'd9);
      idle(8);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // randomized traffic, mostly honouring stall
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         ok = (i >= 400 && i < 440) || !m_stall;
         av = ok && ($urandom_range(0, 2) != 0);
         mv = ok && ($urandom_range(0, 2) == 0);
         dv = ok && ($urandom_range(0, 3) == 0);
         step(r, av, 5'($urandom_range(0, 31)), $urandom,
                 mv, 5'($urandom_range(0, 7)), $urandom,
                 dv, 5'($urandom_range(0, 7)), $urandom);
      end
      idle(10);
      @(posedge clock);
      #1;
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL wr_missing: got %0d writes still outstanding, required 0", exp_wr.size());
      end
      checks++;
      if (exp_ctl.size() > 1) begin
         errors++;
         $display("FAIL ctl_pending: got %0d unchecked cycles, required at most 1", exp_ctl.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
